id_ex_stage: RTL and testbench

ID/EX pipeline boundary of the 5-stage RISC-V core. It sits directly downstream of the decode-stage control unit. It registers that unit's eight control bits together with the decoded operands, and forwards them to EX one cycle later. It also contains load-use hazard detection, which holds the front end and inserts bubbles, plus flush handling for taken branches and a saturating bubble counter.

---
 rtl/id_ex_stage.sv | 183 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage RISC-V core, with load-use hazard detection, branch flush and bubble counting.
// Latency: 1 cycle from ID inputs to ex_* outputs; stall is combinational in the same cycle.
// Backpressure: stall holds PC and IF/ID for one cycle per load-use pair; flush overrides stall.
//
// Optional feature macro: ID_EX_HAZARD_EN
//   defined   -> load-use detection drives stall and inserts bubbles
//   undefined -> hazard and stall are constant 0, only flush/!id_valid bubble
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   id_valid                         ID slot holds a real instruction
//   id_alusrc..id_branch, id_aluop   decode control bits
//   id_pc, id_rs1_data, id_rs2_data  PC and register read data
//   id_imm, id_rs1, id_rs2, id_rd    immediate and register indices
//   id_funct                         {inst[30], funct3}
//   flush                            taken branch: squash the ID instruction
//   ex_*                             registered copies of the id_* fields
//   ex_valid                         EX slot holds a real instruction
//   stall                            hold PC and IF/ID this cycle
//   bubble_cnt                       saturating count of flush/hazard bubbles

module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             id_valid,
    input  logic             id_alusrc,
    input  logic             id_memtoreg,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic             id_branch,
    input  logic [1:0]       id_aluop,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [3:0]       id_funct,
    input  logic             flush,

    output logic             ex_alusrc,
    output logic             ex_memtoreg,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_branch,
    output logic [1:0]       ex_aluop,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [3:0]       ex_funct,
    output logic             ex_valid,
    output logic             stall,
    output logic [CNT_W-1:0] bubble_cnt
);

    // Control word carried through the stage; a bubble zeroes it as a unit.
    typedef struct packed {
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic [1:0] aluop;
    } ctrl_t;

    // Data/index fields; loaded every edge, bubble or not.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      funct;
    } dat_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;
    dat_t  id_dat;
    dat_t  ex_dat;

    logic  hazard;
    logic  bubble_load;
    logic  bubble_count;
    logic  cnt_sat;

    assign id_ctrl = '{
        alusrc:   id_alusrc,
        memtoreg: id_memtoreg,
        regwrite: id_regwrite,
        memread:  id_memread,
        memwrite: id_memwrite,
        branch:   id_branch,
        aluop:    id_aluop
    };

    assign id_dat = '{
        pc:       id_pc,
        rs1_data: id_rs1_data,
        rs2_data: id_rs2_data,
        imm:      id_imm,
        rs1:      id_rs1,
        rs2:      id_rs2,
        rd:       id_rd,
        funct:    id_funct
    };

`ifdef ID_EX_HAZARD_EN
    // Load in EX whose result is needed by the instruction in ID. Both
    // source indices are compared regardless of format; a false stall on
    // an instruction without rs2 costs one cycle and is accepted.
    // x0 is never a real dependency.
    assign hazard = ex_valid & ex_ctrl.memread & (ex_dat.rd != 5'd0) & id_valid &
                    ((ex_dat.rd == id_rs1) | (ex_dat.rd == id_rs2));
`else
    // Loads are scheduled in software; no interlock.
    assign hazard = 1'b0;
`endif

    // A flush redirects the front end, so it must not be held as well.
    assign stall        = hazard & ~flush;

    // Invalid ID slots also bubble so undecoded (possibly X) control never
    // reaches EX, but only flush/hazard bubbles are counted.
    assign bubble_load  = flush | hazard | ~id_valid;
    assign bubble_count = flush | hazard;
    assign cnt_sat      = &bubble_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl    <= '0;
            ex_dat     <= '0;
            ex_valid   <= 1'b0;
            bubble_cnt <= '0;
        end else begin
            ex_dat <= id_dat;
            if (bubble_load) begin
                ex_ctrl  <= '0;
                ex_valid <= 1'b0;
            end else begin
                ex_ctrl  <= id_ctrl;
                ex_valid <= 1'b1;
            end
            // Simultaneous flush and hazard is still a single bubble: +1.
            if (bubble_count && !cnt_sat) begin
                bubble_cnt <= bubble_cnt + CNT_ONE;
            end
        end
    end

    assign ex_alusrc   = ex_ctrl.alusrc;
    assign ex_memtoreg = ex_ctrl.memtoreg;
    assign ex_regwrite = ex_ctrl.regwrite;
    assign ex_memread  = ex_ctrl.memread;
    assign ex_memwrite = ex_ctrl.memwrite;
    assign ex_branch   = ex_ctrl.branch;
    assign ex_aluop    = ex_ctrl.aluop;

    assign ex_pc       = ex_dat.pc;
    assign ex_rs1_data = ex_dat.rs1_data;
    assign ex_rs2_data = ex_dat.rs2_data;
    assign ex_imm      = ex_dat.imm;
    assign ex_rs1      = ex_dat.rs1;
    assign ex_rs2      = ex_dat.rs2;
    assign ex_rd       = ex_dat.rd;
    assign ex_funct    = ex_dat.funct;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: scoreboard of expected EX-stage state per edge.
// Latency: expectation pushed when ID is driven, popped one edge later.
// Backpressure: stall is checked combinationally before each edge.

module tb_id_ex_stage;

    localparam int XLEN = 32;
    localparam int CW   = 4;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    localparam logic [7:0] C_RTYPE = 8'b0010_0010; // regwrite, aluop=10
    localparam logic [7:0] C_LW    = 8'b1111_0000; // alusrc, memtoreg, regwrite, memread

    logic            clk;
    logic            rst_n;
    logic            id_valid;
    logic            id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch;
    logic [1:0]      id_aluop;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic [3:0]      id_funct;
    logic            flush;

    logic            ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch;
    logic [1:0]      ex_aluop;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic [3:0]      ex_funct;
    logic            ex_valid;
    logic            stall;
    logic [CW-1:0]   bubble_cnt;

    typedef struct packed {
        logic            valid;
        logic [7:0]      ctrl;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      funct;
        logic [CW-1:0]   cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t m;           // model of the current EX-stage state
    int   n_checks;
    int   n_fail;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_alusrc   (id_alusrc),
        .id_memtoreg (id_memtoreg),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .id_memwrite (id_memwrite),
        .id_branch   (id_branch),
        .id_aluop    (id_aluop),
        .id_pc       (id_pc),
        .id_rs1_data (id_rs1_data),
        .id_rs2_data (id_rs2_data),
        .id_imm      (id_imm),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_funct    (id_funct),
        .flush       (flush),
        .ex_alusrc   (ex_alusrc),
        .ex_memtoreg (ex_memtoreg),
        .ex_regwrite (ex_regwrite),
        .ex_memread  (ex_memread),
        .ex_memwrite (ex_memwrite),
        .ex_branch   (ex_branch),
        .ex_aluop    (ex_aluop),
        .ex_pc       (ex_pc),
        .ex_rs1_data (ex_rs1_data),
        .ex_rs2_data (ex_rs2_data),
        .ex_imm      (ex_imm),
        .ex_rs1      (ex_rs1),
        .ex_rs2      (ex_rs2),
        .ex_rd       (ex_rd),
        .ex_funct    (ex_funct),
        .ex_valid    (ex_valid),
        .stall       (stall),
        .bubble_cnt  (bubble_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic compare_out(input string tag, input exp_t e);
        check({tag, ".valid"}, 64'(ex_valid), 64'(e.valid));
        check({tag, ".ctrl"},
              64'({ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_aluop}),
              64'(e.ctrl));
        check({tag, ".pc"},   64'(ex_pc),       64'(e.pc));
        check({tag, ".rs1d"}, 64'(ex_rs1_data), 64'(e.rs1_data));
        check({tag, ".rs2d"}, 64'(ex_rs2_data), 64'(e.rs2_data));
        check({tag, ".imm"},  64'(ex_imm),      64'(e.imm));
        check({tag, ".idx"},  64'({ex_rs1, ex_rs2, ex_rd, ex_funct}),
              64'({e.rs1, e.rs2, e.rd, e.funct}));
        check({tag, ".cnt"},  64'(bubble_cnt),  64'(e.cnt));
    endtask

    // Load-use dependency of the ID instruction on the modelled EX state.
    function automatic logic model_hazard();
`ifdef ID_EX_HAZARD_EN
        return m.valid && m.ctrl[4] && (m.rd != 5'd0) && id_valid &&
               ((m.rd == id_rs1) || (m.rd == id_rs2));
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive(input logic v, input logic [7:0] c, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rdi,
                         input logic [XLEN-1:0] pc, input logic fl);
        id_valid = v;
        {id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch, id_aluop} = c;
        id_rs1      = r1;
        id_rs2      = r2;
        id_rd       = rdi;
        id_pc       = pc;
        flush       = fl;
        id_rs1_data = $urandom;
        id_rs2_data = $urandom;
        id_imm      = $urandom;
        id_funct    = 4'($urandom);
    endtask

    // Called at a falling edge with ID inputs already driven; returns at the next falling edge.
    task automatic step(input string tag);
        exp_t n;
        logic hz;
        logic bub;
        #1;
        hz = model_hazard();
        check({tag, ".stall"}, 64'(stall), 64'(hz && !flush));
        bub        = flush || hz || !id_valid;
        n.valid    = !bub;
        n.ctrl     = bub ? 8'h00
                         : {id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch, id_aluop};
        n.pc       = id_pc;
        n.rs1_data = id_rs1_data;
        n.rs2_data = id_rs2_data;
        n.imm      = id_imm;
        n.rs1      = id_rs1;
        n.rs2      = id_rs2;
        n.rd       = id_rd;
        n.funct    = id_funct;
        n.cnt      = ((flush || hz) && (m.cnt != CNT_MAX)) ? m.cnt + 1'b1 : m.cnt;
        sb_q.push_back(n);
        @(posedge clk);
        #1;
        check({tag, ".sb_size"}, 64'(sb_q.size()), 64'd1);
        if (sb_q.size() != 0) begin
            m = sb_q.pop_front();
            compare_out(tag, m);
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m        = '0;
        rst_n    = 1'b0;
        drive(1'b1, 8'hFF, 5'd1, 5'd2, 5'd3, 32'h1234, 1'b0);
        #1;
        compare_out("reset0", '0);
        check("reset0.stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // R-type pass-through
        drive(1'b1, C_RTYPE, 5'd1, 5'd2, 5'd5, 32'h40, 1'b0);
        step("rtype");

        // Load-use on rs2: stall (if enabled), bubble, then dependent loads
        drive(1'b1, C_LW, 5'd1, 5'd0, 5'd7, 32'h44, 1'b0);
        step("lu_load");
        drive(1'b1, C_RTYPE, 5'd4, 5'd7, 5'd8, 32'h48, 1'b0);
        step("lu_dep");
        step("lu_dep_again");

        // x0 destination never stalls
        drive(1'b1, C_LW, 5'd2, 5'd0, 5'd0, 32'h4C, 1'b0);
        step("x0_load");
        drive(1'b1, C_RTYPE, 5'd0, 5'd3, 5'd9, 32'h50, 1'b0);
        step("x0_dep");

        // Flush coinciding with a hazard: one bubble, no stall, +1
        drive(1'b1, C_LW, 5'd1, 5'd0, 5'd9, 32'h54, 1'b0);
        step("fh_load");
        drive(1'b1, C_RTYPE, 5'd9, 5'd9, 5'd10, 32'h58, 1'b1);
        step("fh_dep");

        // Back-to-back dependents: one stall only
        drive(1'b1, C_LW, 5'd1, 5'd0, 5'd3, 32'h5C, 1'b0);
        step("bb_load");
        drive(1'b1, C_RTYPE, 5'd3, 5'd1, 5'd11, 32'h60, 1'b0);
        step("bb_dep1");
        step("bb_dep1_held");
        drive(1'b1, C_RTYPE, 5'd1, 5'd3, 5'd12, 32'h64, 1'b0);
        step("bb_dep2");

        // Invalid slot bubbles without counting
        drive(1'b0, 8'hFF, 5'd1, 5'd2, 5'd3, 32'h68, 1'b0);
        step("invalid");

        // Random traffic with small register indices to provoke hazards
        for (int i = 0; i < 150; i++) begin
            drive($urandom_range(0, 7) != 0, 8'($urandom), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom,
                  $urandom_range(0, 7) == 0);
            step("rand");
        end

        // Asynchronous reset mid-cycle with busy inputs
        drive(1'b1, 8'hFF, 5'd6, 5'd7, 5'd8, 32'hFFFF_FFFC, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        compare_out("mid_reset", '0);
        check("mid_reset.stall", 64'(stall), 64'd0);
        m = '0;
        @(posedge clk);
        #1;
        compare_out("mid_reset_edge", '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation: 20 flushes on a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, C_RTYPE, 5'd1, 5'd2, 5'd3, 32'(i * 4), 1'b1);
            step("sat");
        end
        check("sat_final", 64'(bubble_cnt), 64'(CNT_MAX));
        drive(1'b1, C_RTYPE, 5'd1, 5'd2, 5'd3, 32'h100, 1'b0);
        step("sat_hold");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
